dmem_arbiter: RTL and testbench

- Shares the single-port data memory (synchronous, one read/write per clock, read data registered at the clock edge) between two requesters.
  - Requester 0: the execute stage load/store path.
  - Requester 1: a loader/debug port.
- Round-robin arbitration with a valid/grant handshake.
- One registered issue stage drives the memory; read data is routed back to the owning requester with a fixed latency.

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Requester ids, default widths and the issue-stage entry.
package dmem_arb_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    localparam logic REQ_EXE = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic              id;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] wdata;
    } issue_t;

    // Id of the requester selected by a one-hot grant vector.
    function automatic logic gnt_id(input logic [1:0] gnt);
        return gnt[1] ? REQ_LDR : REQ_EXE;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ties go to the requester that did not win last time.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;

    // Grant: single requester wins outright, ties alternate.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == REQ_LDR) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer remembers the last winner; reset favours requester 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= REQ_LDR;
        end else if (|gnt) begin
            last_q <= gnt_id(gnt);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between execute and loader.
// Grant in T, memory access in T+1, read data back in T+2.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // The issue entry is a packed struct of the package widths.
    if (AW != DEF_AW || DW != DEF_DW) begin : g_width_check
        $error("dmem_arbiter: AW/DW must match dmem_arb_pkg");
    end

    logic [1:0]    gnt;
    issue_t        iss_q;
    logic          ret_valid_q;
    logic          ret_id_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({req1, req0}),
        .gnt     (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Issue stage: capture the accepted request for one memory cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iss_q <= '0;
        end else begin
            iss_q.valid <= |gnt;
            if (|gnt) begin
                iss_q.id    <= gnt_id(gnt);
                iss_q.we    <= gnt[1] ? we1    : we0;
                iss_q.addr  <= gnt[1] ? addr1  : addr0;
                iss_q.wdata <= gnt[1] ? wdata1 : wdata0;
            end
        end
    end

    assign mem_read  = iss_q.valid & ~iss_q.we;
    assign mem_write = iss_q.valid &  iss_q.we;
    assign mem_addr  = iss_q.addr;
    assign mem_wdata = iss_q.wdata;

    // Return pipe: tag the read so its data lands at the right owner.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ret_valid_q <= 1'b0;
            ret_id_q    <= REQ_EXE;
        end else begin
            ret_valid_q <= mem_read;
            ret_id_q    <= iss_q.id;
        end
    end

    assign rvalid0 = ret_valid_q & (ret_id_q == REQ_EXE);
    assign rvalid1 = ret_valid_q & (ret_id_q == REQ_LDR);

    // Read data holding: keep the last returned word per requester.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) rdata0_q <= mem_rdata;
            if (rvalid1) rdata1_q <= mem_rdata;
        end
    end

    assign rdata0 = rvalid0 ? mem_rdata : rdata0_q;
    assign rdata1 = rvalid1 ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table plus a reset
// sequence, against a small synchronous memory model.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem [256] = '{2: 32'd30, default: 32'd0};

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port memory with registered read data.
    always @(posedge clock) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
    end

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mr, mw;
        logic [31:0] ma, md;
        logic        rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic r0, w0, input logic [31:0] a0, d0,
        input logic r1, w1, input logic [31:0] a1, d1,
        input logic g0, g1, mr, mw,
        input logic [31:0] ma, md,
        input logic rv0, rv1, input logic [31:0] rd0, rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mr = mr; v.mw = mw;
        v.ma = ma; v.md = md;
        v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    initial begin
        // Cycle-by-cycle vectors; columns:
        // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 mr mw ma md | rv0 rv1 rd0 rd1
        tbl[0]  = mk(1,0,2,0,   0,0,0,0,  1,0,0,0,0,0,   0,0,0,0);
        tbl[1]  = mk(0,0,0,0,   0,0,0,0,  0,0,1,0,2,0,   0,0,0,0);
        tbl[2]  = mk(0,0,0,0,   0,0,0,0,  0,0,0,0,0,0,   1,0,30,0);
        tbl[3]  = mk(0,0,0,0,   1,1,5,99, 0,1,0,0,0,0,   0,0,30,0);
        tbl[4]  = mk(1,0,5,0,   0,0,0,0,  1,0,0,1,5,99,  0,0,30,0);
        tbl[5]  = mk(0,0,0,0,   0,0,0,0,  0,0,1,0,5,0,   0,0,30,0);
        tbl[6]  = mk(0,0,0,0,   0,0,0,0,  0,0,0,0,0,0,   1,0,99,0);
        tbl[7]  = mk(0,0,0,0,   1,0,2,0,  0,1,0,0,0,0,   0,0,99,0);
        tbl[8]  = mk(0,0,0,0,   0,0,0,0,  0,0,1,0,2,0,   0,0,99,0);
        tbl[9]  = mk(0,0,0,0,   0,0,0,0,  0,0,0,0,0,0,   0,1,99,30);
        tbl[10] = mk(1,0,5,0,   1,1,7,7,  1,0,0,0,0,0,   0,0,99,30);
        tbl[11] = mk(1,0,2,0,   1,1,7,7,  0,1,1,0,5,0,   0,0,99,30);
        tbl[12] = mk(1,0,2,0,   1,1,8,8,  1,0,0,1,7,7,   1,0,99,30);
        tbl[13] = mk(1,0,7,0,   1,1,8,8,  0,1,1,0,2,0,   0,0,99,30);
        tbl[14] = mk(1,0,7,0,   0,0,0,0,  1,0,0,1,8,8,   1,0,30,30);
        tbl[15] = mk(0,0,0,0,   0,0,0,0,  0,0,1,0,7,0,   0,0,30,30);
        tbl[16] = mk(0,0,0,0,   0,0,0,0,  0,0,0,0,0,0,   1,0,7,30);
        tbl[17] = mk(1,1,0,10,  0,0,0,0,  1,0,0,0,0,0,   0,0,7,30);
        tbl[18] = mk(1,1,1,11,  0,0,0,0,  1,0,0,1,0,10,  0,0,7,30);
        tbl[19] = mk(1,1,2,12,  0,0,0,0,  1,0,0,1,1,11,  0,0,7,30);
        tbl[20] = mk(1,1,3,13,  0,0,0,0,  1,0,0,1,2,12,  0,0,7,30);
        tbl[21] = mk(0,0,0,0,   0,0,0,0,  0,0,0,1,3,13,  0,0,7,30);
        for (int i = 22; i < NV; i++)
            tbl[i] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,7,30);

        // Reset state, with a tie to probe the reset pointer.
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_rvalid1", 32'(rvalid1), 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("rst_tie_gnt0", 32'(gnt0), 1);
        chk("rst_tie_gnt1", 32'(gnt1), 0);
        idle_inputs();
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Vector table, one row per clock.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            @(negedge clock);
            chk($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
            chk($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
            chk($sformatf("v%0d_mem_read", i),
                32'(mem_read), 32'(tbl[i].mr));
            chk($sformatf("v%0d_mem_write", i),
                32'(mem_write), 32'(tbl[i].mw));
            chk($sformatf("v%0d_strobe_excl", i),
                32'(mem_read & mem_write), 0);
            if (tbl[i].mr || tbl[i].mw)
                chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].ma);
            if (tbl[i].mw)
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].md);
            chk($sformatf("v%0d_rvalid0", i),
                32'(rvalid0), 32'(tbl[i].rv0));
            chk($sformatf("v%0d_rvalid1", i),
                32'(rvalid1), 32'(tbl[i].rv1));
            chk($sformatf("v%0d_rdata0", i), rdata0, tbl[i].rd0);
            chk($sformatf("v%0d_rdata1", i), rdata1, tbl[i].rd1);
            @(posedge clock);
            #1;
        end

        // Writes landed in memory in grant order.
        chk("mem_word0", mem[0], 10);
        chk("mem_word3", mem[3], 13);
        chk("mem_word7", mem[7], 7);

        // Reset in the issue cycle of a read.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
        @(negedge clock);
        chk("rr_gnt0", 32'(gnt0), 1);
        @(posedge clock);
        #1;
        idle_inputs();
        chk("rr_issue_read", 32'(mem_read), 1);
        chk("rr_issue_addr", mem_addr, 3);
        #1 reset_n = 1'b0;
        #1;
        chk("rr_read_dropped", 32'(mem_read), 0);
        chk("rr_addr_cleared", mem_addr, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("rr_no_rvalid0_%0d", i), 32'(rvalid0), 0);
            chk($sformatf("rr_rdata0_%0d", i), rdata0, 0);
            @(posedge clock);
            #1;
        end

        // First tie after reset goes to requester 0.
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clock);
        chk("rr_tie_gnt0", 32'(gnt0), 1);
        chk("rr_tie_gnt1", 32'(gnt1), 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rr_tie2_gnt1", 32'(gnt1), 1);
        chk("rr_tie2_gnt0", 32'(gnt0), 0);
        @(posedge clock);
        #1 idle_inputs();
        repeat (3) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
